risc_controller: RTL

//  Instruction register + control FSM sitting directly upstream of the RISC datapath.

---
 rtl/risc_defs.sv | 37 +++
 rtl/risc_decoder.sv | 18 +
 rtl/risc_controller.sv | 118 +++++++++++
 3 files changed

// File: rtl/risc_defs.sv
// Shared encodings for the RISC controller: instruction opcode/op fields,
// ALU and shifter codes, and the control FSM state encoding.
package risc_defs;

  localparam logic [2:0] OPC_MOV = 3'b110;
  localparam logic [2:0] OPC_ALU = 3'b101;

  localparam logic [1:0] OP_MOV_IMM = 2'b10;
  localparam logic [1:0] OP_MOV_REG = 2'b00;
  localparam logic [1:0] OP_ADD     = 2'b00;
  localparam logic [1:0] OP_CMP     = 2'b01;
  localparam logic [1:0] OP_AND     = 2'b10;
  localparam logic [1:0] OP_MVN     = 2'b11;

  localparam logic [1:0] ALU_ADD  = 2'b00;
  localparam logic [1:0] SH_NONE  = 2'b00;

  typedef enum logic [2:0] {
    S_WAIT   = 3'd0,
    S_DECODE = 3'd1,
    S_GET_A  = 3'd2,
    S_GET_B  = 3'd3,
    S_ALU    = 3'd4,
    S_WR_REG = 3'd5,
    S_WR_IMM = 3'd6
  } state_t;

  typedef struct packed {
    logic [2:0] opcode;
    logic [1:0] op;
    logic [2:0] rn;
    logic [2:0] rd;
    logic [1:0] sh;
    logic [2:0] rm;
  } ir_fields_t;

endpackage

// File: rtl/risc_decoder.sv
// Combinational IR field extraction and sign extension of the two immediates.
module risc_decoder
  import risc_defs::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [15:0]      ir,
  output ir_fields_t       fields,
  output logic [WIDTH-1:0] sximm5,
  output logic [WIDTH-1:0] sximm8
);

  assign fields = '{opcode: ir[15:13], op: ir[12:11], rn: ir[10:8],
                    rd: ir[7:5], sh: ir[4:3], rm: ir[2:0]};
  assign sximm5 = {{(WIDTH-5){ir[4]}}, ir[4:0]};
  assign sximm8 = {{(WIDTH-8){ir[7]}}, ir[7:0]};

endmodule

// File: rtl/risc_controller.sv
// Instruction register plus control FSM that sequences the datapath strobes
// for MOV imm, MOV reg, ADD, CMP, AND and MVN.
module risc_controller
  import risc_defs::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [15:0]      in,
  input  logic             load,
  input  logic             s,
  output logic             w,
  output logic [2:0]       readnum,
  output logic [2:0]       writenum,
  output logic             write,
  output logic             loada,
  output logic             loadb,
  output logic             loadc,
  output logic             loads,
  output logic             asel,
  output logic             bsel,
  output logic             vsel,
  output logic [1:0]       shift,
  output logic [1:0]       ALUop,
  output logic [WIDTH-1:0] sximm5,
  output logic [WIDTH-1:0] sximm8
);

  state_t      state;
  logic [15:0] ir;
  ir_fields_t  f;

  risc_decoder #(.WIDTH(WIDTH)) u_dec (
    .ir     (ir),
    .fields (f),
    .sximm5 (sximm5),
    .sximm8 (sximm8)
  );

  logic is_mov_imm, is_mov_reg, is_add, is_cmp, is_and, is_mvn;
  assign is_mov_imm = (f.opcode == OPC_MOV) && (f.op == OP_MOV_IMM);
  assign is_mov_reg = (f.opcode == OPC_MOV) && (f.op == OP_MOV_REG);
  assign is_add     = (f.opcode == OPC_ALU) && (f.op == OP_ADD);
  assign is_cmp     = (f.opcode == OPC_ALU) && (f.op == OP_CMP);
  assign is_and     = (f.opcode == OPC_ALU) && (f.op == OP_AND);
  assign is_mvn     = (f.opcode == OPC_ALU) && (f.op == OP_MVN);

  // IR only accepts new words while idle, so a mid-instruction load is dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_WAIT;
      ir    <= '0;
    end else begin
      case (state)
        S_WAIT: begin
          if (load) ir <= in;
          if (s) state <= S_DECODE;
        end
        S_DECODE: begin
          if (is_mov_imm)                    state <= S_WR_IMM;
          else if (is_mov_reg || is_mvn)     state <= S_GET_B;
          else if (is_add || is_and || is_cmp) state <= S_GET_A;
          else                               state <= S_WAIT;
        end
        S_GET_A:  state <= S_GET_B;
        S_GET_B:  state <= S_ALU;
        S_ALU:    state <= is_cmp ? S_WAIT : S_WR_REG;
        default:  state <= S_WAIT;
      endcase
    end
  end

  assign w    = (state == S_WAIT);
  assign bsel = 1'b0;

  always_comb begin
    readnum  = '0;
    writenum = '0;
    write    = 1'b0;
    loada    = 1'b0;
    loadb    = 1'b0;
    loadc    = 1'b0;
    loads    = 1'b0;
    asel     = 1'b0;
    vsel     = 1'b0;
    shift    = SH_NONE;
    ALUop    = ALU_ADD;
    case (state)
      S_GET_A: begin
        readnum = f.rn;
        loada   = 1'b1;
      end
      S_GET_B: begin
        readnum = f.rm;
        loadb   = 1'b1;
      end
      S_ALU: begin
        shift = f.sh;
        ALUop = is_mov_reg ? ALU_ADD : f.op;
        asel  = is_mov_reg || is_mvn;
        loadc = !is_cmp;
        loads = is_cmp;
      end
      S_WR_REG: begin
        writenum = f.rd;
        write    = 1'b1;
      end
      S_WR_IMM: begin
        writenum = f.rn;
        vsel     = 1'b1;
        write    = 1'b1;
      end
      default: ;
    endcase
  end

endmodule
